tbird_ctrl: RTL and testbench
=============================

TBIRD_CTRL -- requirements
Module: tbird_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, which sets the width of the tick-divider configuration.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset; one clock and synchronous active-high reset are fixed.
REQ-004 SHALL have port left_req, input, 1, left turn request (level or pulse).
REQ-005 SHALL have port right_req, input, 1, right turn request (level or pulse).
REQ-006 SHALL have port haz_req, input, 1, hazard request (level or pulse).
REQ-007 SHALL have port brake, input, 1, brake pedal level.
REQ-008 SHALL have port cfg_div, input, DIV_W, which sets the tick period to cfg_div+1 clocks.
REQ-009 SHALL have port l_lights, output, 3, left lamps; bit0 is innermost.
REQ-010 SHALL have port r_lights, output, 3, right lamps; bit0 is innermost.
REQ-011 SHALL have port busy, output, 1, high when the sequencer is not IDLE.
REQ-012 SHALL have port tick, output, 1, a one-cycle step pulse.

Function
REQ-013 SHALL implement the prescaler cnt with width DIV_W, using these rules:
- tick=1 when cnt>=cfg_div, and cnt returns to 0 on that cycle;
- otherwise cnt increments;
- cfg_div=0 gives tick every cycle;
- lowering cfg_div below cnt gives tick on the next cycle.
REQ-014 SHALL keep sticky pending flags pl, pr, ph:
- each flag is set on any cycle its request is high;
- a flag is cleared only when its request is consumed per REQ-016;
- a request arriving on the consume cycle remains pending.
REQ-015 SHALL hold the sequencer states IDLE, L1, L2, L3, R1, R2, R3, LR3; state changes only on tick cycles.
REQ-016 SHALL arbitrate from IDLE on tick using eff = pending OR current request, with these priorities:
- eff ph, or both eff pl and eff pr: go to LR3 and consume all three flags;
- else eff pl: go to L1 and consume pl;
- else eff pr: go to R1 and consume pr;
- else stay in IDLE.
REQ-017 SHALL step the left sequence L1->L2->L3->IDLE and the right sequence R1->R2->R3->IDLE, one step per tick.
REQ-018 SHALL abort a sequence on tick from L1, L2, R1 or R2 when eff ph is set: go to LR3 and consume ph; L3 and R3 always return to IDLE.
REQ-019 SHALL return from LR3 to IDLE on tick; a still-pending hazard re-enters LR3 on the following tick, so the lamps flash.
REQ-020 SHALL decode lights combinationally from state:
- IDLE: 000 / 000;
- L1 / L2 / L3: 001 / 011 / 111 on the left side, 000 on the right;
- R1 / R2 / R3: mirror of L1 / L2 / L3;
- LR3: 111 / 111.
REQ-021 SHALL have tick-to-lights latency of one clock: the state register updates on the edge that ends the tick cycle.
REQ-022 SHALL drive busy = (state != IDLE), combinationally.

Reset
REQ-023 SHALL set the following while rst is high at a clock edge:
- state=IDLE, cnt=0, pl=pr=ph=0;
- outputs l_lights=000, r_lights=000, busy=0, tick=0.
REQ-024 SHALL abandon any sequence mid-operation when rst is asserted, with no completion; a request held through reset re-latches on the first cycle after reset.

Configuration
REQ-025 SHALL compile brake override under macro TBIRD_BRAKE_EN, which when defined gives brake=1 these effects:
- the side not sequencing shows 111;
- in IDLE both sides show 111;
- in LR3 there is no change;
- the state machine is unaffected.
REQ-026 SHALL ignore brake entirely when TBIRD_BRAKE_EN is undefined.

Structure
REQ-027 SHALL place the state enum t_tbird_lights_state (3-bit encoding IDLE=000, L1=001, L2=011, L3=010, R1=101, R2=110, R3=111, LR3=100) in package tbird_pkg.
REQ-028 SHALL place the lamp pattern constants (OFF=000, ONE=001, TWO=011, ALL=111) in package tbird_pkg.
REQ-029 SHALL implement the prescaler as sub-module tbird_tick_gen, with ports clk, rst, cfg_div, tick.

Verification
REQ-030 SHALL cover this scenario: cfg_div=3, one-cycle left_req pulse -> L1, L2, L3, IDLE at 4-clock spacing, l_lights 001, 011, 111, 000.
REQ-031 SHALL cover this scenario: cfg_div=0, left_req and right_req high together in IDLE -> LR3 for 1 cycle, then IDLE; pl and pr are cleared.
REQ-032 SHALL cover this scenario: cfg_div=2, haz_req pulse while in L2 -> LR3 on the next tick, l=r=111, then IDLE.
REQ-033 SHALL cover this scenario: right_req pulse during L1 -> the left sequence completes, then R1 on the first tick after IDLE.
REQ-034 SHALL cover this scenario: rst asserted in R2 -> all outputs 000 and busy=0 on the next cycle, with pendings cleared.
REQ-035 SHALL cover this scenario with TBIRD_BRAKE_EN defined: brake=1 during L2 -> l=011, r=111; brake=1 in IDLE -> l=r=111.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared types and lamp constants for the tail-light sequencer.
// State encoding is fixed for compatibility with existing lamp-driver firmware.
package tbird_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    L1   = 3'b001,
    L2   = 3'b011,
    L3   = 3'b010,
    R1   = 3'b101,
    R2   = 3'b110,
    R3   = 3'b111,
    LR3  = 3'b100
  } t_tbird_lights_state;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] ONE = 3'b001;
  localparam logic [2:0] TWO = 3'b011;
  localparam logic [2:0] ALL = 3'b111;

endpackage

// File: rtl/tbird_tick_gen.sv
// Step prescaler: one-cycle tick every cfg_div+1 clocks, combinational from cnt.
// Latency: tick asserted in the cycle cnt reaches cfg_div; no backpressure.
module tbird_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // >= rather than == so lowering cfg_div below cnt ticks immediately
  assign wrap = (cnt >= cfg_div);
  assign tick = wrap & ~rst;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/tbird_ctrl.sv
// Thunderbird tail-light sequencer: sticky turn/hazard requests, stepped on tick.
// Lights follow state one clock after a tick; optional brake override under TBIRD_BRAKE_EN.
module tbird_ctrl
  import tbird_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             haz_req,
  input  logic             brake,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [2:0]       l_lights,
  output logic [2:0]       r_lights,
  output logic             busy,
  output logic             tick
);

  t_tbird_lights_state state, state_nxt;
  logic pl, pr, ph;
  logic eff_l, eff_r, eff_h;
  logic con_l, con_r, con_h;
  logic [2:0] base_l, base_r;

  tbird_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .cfg_div(cfg_div),
    .tick   (tick)
  );

  assign eff_l = pl | left_req;
  assign eff_r = pr | right_req;
  assign eff_h = ph | haz_req;

  always_comb begin
    state_nxt = state;
    con_l     = 1'b0;
    con_r     = 1'b0;
    con_h     = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (eff_h || (eff_l && eff_r)) begin
            state_nxt = LR3;
            {con_l, con_r, con_h} = 3'b111;
          end else if (eff_l) begin
            state_nxt = L1;
            con_l     = 1'b1;
          end else if (eff_r) begin
            state_nxt = R1;
            con_r     = 1'b1;
          end
        end
        L1, L2, R1, R2: begin
          if (eff_h) begin
            state_nxt = LR3;
            con_h     = 1'b1;
          end else begin
            case (state)
              L1:      state_nxt = L2;
              L2:      state_nxt = L3;
              R1:      state_nxt = R2;
              default: state_nxt = R3;
            endcase
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A consumed flag survives only if it was already pending and a fresh request lands now
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pl    <= 1'b0;
      pr    <= 1'b0;
      ph    <= 1'b0;
    end else begin
      state <= state_nxt;
      pl    <= con_l ? (pl & left_req)  : (pl | left_req);
      pr    <= con_r ? (pr & right_req) : (pr | right_req);
      ph    <= con_h ? (ph & haz_req)   : (ph | haz_req);
    end
  end

  always_comb begin
    base_l = OFF;
    base_r = OFF;
    case (state)
      L1:      base_l = ONE;
      L2:      base_l = TWO;
      L3:      base_l = ALL;
      R1:      base_r = ONE;
      R2:      base_r = TWO;
      R3:      base_r = ALL;
      LR3: begin
        base_l = ALL;
        base_r = ALL;
      end
      default: ;
    endcase
  end

`ifdef TBIRD_BRAKE_EN
  // A side that is not sequencing shows full brake; LR3 already lights both
  assign l_lights = (brake && (base_l == OFF)) ? ALL : base_l;
  assign r_lights = (brake && (base_r == OFF)) ? ALL : base_r;
`else
  logic unused_brake;
  assign unused_brake = brake;
  assign l_lights     = base_l;
  assign r_lights     = base_r;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tbird_ctrl.sv
// Bench for tbird_ctrl: directed scenarios then random requests, against a mode/step model.
module tb_tbird_ctrl;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             left_req, right_req, haz_req, brake;
  logic [DIV_W-1:0] cfg_div;
  logic [2:0]       l_lights, r_lights;
  logic             busy, tick;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0=idle 1=left 2=right 3=hazard, step 1..3 within a turn sequence
  int m_mode, m_step, m_cnt;
  bit m_pl, m_pr, m_ph;

  tbird_ctrl #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .left_req (left_req),
    .right_req(right_req),
    .haz_req  (haz_req),
    .brake    (brake),
    .cfg_div  (cfg_div),
    .l_lights (l_lights),
    .r_lights (r_lights),
    .busy     (busy),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] bar(int n);
    return 3'((1 << n) - 1);
  endfunction

  function automatic logic [2:0] exp_side(int side);
    logic [2:0] v;
    if (m_mode == 3)         v = 3'b111;
    else if (m_mode == side) v = bar(m_step);
    else                     v = 3'b000;
`ifdef TBIRD_BRAKE_EN
    if (brake && m_mode != 3 && m_mode != side) v = 3'b111;
`endif
    return v;
  endfunction

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_update();
    bit t, el, er, eh, cl, cr, ch;
    if (rst) begin
      m_mode = 0; m_step = 0; m_cnt = 0;
      m_pl = 0; m_pr = 0; m_ph = 0;
      return;
    end
    t  = (m_cnt >= int'(cfg_div));
    el = m_pl | left_req;
    er = m_pr | right_req;
    eh = m_ph | haz_req;
    cl = 0; cr = 0; ch = 0;
    if (t) begin
      if (m_mode == 0) begin
        if (eh || (el && er)) begin m_mode = 3; cl = 1; cr = 1; ch = 1; end
        else if (el)          begin m_mode = 1; m_step = 1; cl = 1; end
        else if (er)          begin m_mode = 2; m_step = 1; cr = 1; end
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if (m_step == 3) begin
        m_mode = 0;
      end else if (eh) begin
        m_mode = 3; ch = 1;
      end else begin
        m_step++;
      end
    end
    m_cnt = t ? 0 : m_cnt + 1;
    m_pl  = cl ? (m_pl & left_req)  : (m_pl | left_req);
    m_pr  = cr ? (m_pr & right_req) : (m_pr | right_req);
    m_ph  = ch ? (m_ph & haz_req)   : (m_ph | haz_req);
  endtask

  // Inputs are applied just after a falling edge; check, then advance one clock
  task automatic cycle();
    #1;
    chk("l_lights", l_lights, exp_side(1));
    chk("r_lights", r_lights, exp_side(2));
    chk("busy", {2'b00, busy}, {2'b00, (m_mode != 0)});
    chk("tick", {2'b00, tick}, {2'b00, (!rst && m_cnt >= int'(cfg_div))});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic pulse(bit l, bit r, bit h);
    left_req = l; right_req = r; haz_req = h;
    cycle();
    left_req = 0; right_req = 0; haz_req = 0;
  endtask

  task automatic run_until(int mode, int step);
    for (int i = 0; i < 64 && !(m_mode == mode && m_step == step); i++) cycle();
  endtask

  initial begin
    rst = 1; left_req = 0; right_req = 0; haz_req = 0; brake = 0; cfg_div = 8'd3;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;

    // Left sweep at 4-clock spacing
    pulse(1, 0, 0);
    repeat (20) cycle();

    // Simultaneous left+right with tick every clock
    cfg_div = 8'd0;
    pulse(1, 1, 0);
    repeat (6) cycle();

    // Hazard abort from L2
    cfg_div = 8'd2;
    pulse(1, 0, 0);
    run_until(1, 2);
    pulse(0, 0, 1);
    repeat (12) cycle();

    // Right request queued behind a left sequence
    pulse(1, 0, 0);
    run_until(1, 1);
    pulse(0, 1, 0);
    repeat (24) cycle();

    // Reset mid-right-sequence, then a request held through reset
    pulse(0, 1, 0);
    run_until(2, 2);
    rst = 1;
    cycle();
    cycle();
    right_req = 1;
    cycle();
    rst = 0;
    cycle();
    right_req = 0;
    repeat (16) cycle();

    // Brake during L2 and in IDLE
    pulse(1, 0, 0);
    run_until(1, 2);
    brake = 1;
    cycle();
    cycle();
    run_until(0, 3);
    repeat (4) cycle();
    brake = 0;
    repeat (4) cycle();

    // Held hazard flashes
    haz_req = 1;
    repeat (12) cycle();
    haz_req = 0;
    repeat (10) cycle();

    for (int i = 0; i < 3000; i++) begin
      left_req  = ($urandom_range(0, 15) == 0);
      right_req = ($urandom_range(0, 15) == 0);
      haz_req   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 20) == 0) brake = ~brake;
      if ($urandom_range(0, 60) == 0) cfg_div = 8'($urandom_range(0, 6));
      rst = ($urandom_range(0, 250) == 0);
      cycle();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
